// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lab3_mem_blocking_cache_base_ctrl
//  Purpose  : Control FSM for a blocking, direct-mapped, write-back,
//             write-allocate cache; owns per-line valid/dirty state.
//  Revision : 1.0 - initial release
// ============================================================================
module lab3_mem_blocking_cache_base_ctrl #(
    parameter int p_num_lines = 16,
    parameter int p_idx_shamt = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cachereq_val,
    output logic        cachereq_rdy,
    output logic        cacheresp_val,
    input  logic        cacheresp_rdy,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic        memresp_val,
    output logic        memresp_rdy,

    output logic        cachereq_en,
    output logic        memresp_en,
    output logic        evict_addr_reg_en,
    output logic        read_data_reg_en,
    output logic [2:0]  read_word_mux_sel,
    output logic        write_data_mux_sel,
    output logic        memreq_addr_mux_sel,
    output logic        tag_array_ren,
    output logic        tag_array_wen,
    output logic        data_array_ren,
    output logic        data_array_wen,
    output logic [15:0] data_array_wben,
    output logic        hit,
    output logic [2:0]  cacheresp_type,
    output logic [2:0]  memreq_type,

    input  logic [2:0]  cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic        tag_match
);

    localparam int          c_IDX_W   = $clog2(p_num_lines);
    localparam logic [15:0] c_WORD_BE = 16'h000F;
    localparam logic [2:0]  c_TYPE_RD = 3'd0;
    localparam logic [2:0]  c_TYPE_WR = 3'd1;
    localparam logic [2:0]  c_TYPE_IN = 3'd2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_TC   = 4'd1,
        S_IN   = 4'd2,
        S_RD   = 4'd3,
        S_WD   = 4'd4,
        S_EP   = 4'd5,
        S_ER   = 4'd6,
        S_EW   = 4'd7,
        S_RR   = 4'd8,
        S_RW   = 4'd9,
        S_RU   = 4'd10,
        S_WAIT = 4'd11
    } state_t;

    state_t                 state_q, state_d;
    logic [p_num_lines-1:0] valid_q, valid_d;
    logic [p_num_lines-1:0] dirty_q, dirty_d;
    logic                   hit_q;

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_is_rd;
    logic               w_is_wr;
    logic               w_is_init;
    logic               w_hit;
    logic [15:0]        w_word_wben;
    logic               w_unused_addr;

    assign w_idx         = cachereq_addr[c_IDX_W+p_idx_shamt+3 : p_idx_shamt+4];
    assign w_off         = cachereq_addr[3:2];
    assign w_is_rd       = (cachereq_type == c_TYPE_RD);
    assign w_is_wr       = (cachereq_type == c_TYPE_WR);
    assign w_is_init     = (cachereq_type == c_TYPE_IN);
    assign w_hit         = valid_q[w_idx] & tag_match;
    assign w_word_wben   = c_WORD_BE << {w_off, 2'b00};
    assign w_unused_addr = ^cachereq_addr;

    assign hit            = hit_q;
    assign cacheresp_type = cachereq_type;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            if (state_q == S_TC) begin
                hit_q <= w_hit;
            end
        end
    end

    // Every output is forced low while reset is held, so an abandoned
    // transaction cannot write the arrays or hold a handshake open.
    always_comb begin
        state_d             = state_q;
        valid_d             = valid_q;
        dirty_d             = dirty_q;
        cachereq_rdy        = 1'b0;
        cacheresp_val       = 1'b0;
        memreq_val          = 1'b0;
        memresp_rdy         = 1'b0;
        cachereq_en         = 1'b0;
        memresp_en          = 1'b0;
        evict_addr_reg_en   = 1'b0;
        read_data_reg_en    = 1'b0;
        read_word_mux_sel   = 3'd0;
        write_data_mux_sel  = 1'b0;
        memreq_addr_mux_sel = 1'b0;
        tag_array_ren       = 1'b0;
        tag_array_wen       = 1'b0;
        data_array_ren      = 1'b0;
        data_array_wen      = 1'b0;
        data_array_wben     = 16'h0000;
        memreq_type         = 3'd0;

        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    cachereq_rdy = 1'b1;
                    cachereq_en  = 1'b1;
                    if (cachereq_val) state_d = S_TC;
                end
                S_TC: begin
                    tag_array_ren = 1'b1;
                    if (w_is_init)                         state_d = S_IN;
                    else if (w_hit && w_is_rd)             state_d = S_RD;
                    else if (w_hit && w_is_wr)             state_d = S_WD;
                    else if (valid_q[w_idx] && dirty_q[w_idx]) state_d = S_EP;
                    else                                   state_d = S_RR;
                end
                S_IN: begin
                    tag_array_wen   = 1'b1;
                    data_array_wen  = 1'b1;
                    data_array_wben = w_word_wben;
                    valid_d[w_idx]  = 1'b1;
                    dirty_d[w_idx]  = 1'b0;
                    state_d         = S_WAIT;
                end
                S_RD: begin
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                    state_d          = S_WAIT;
                end
                S_WD: begin
                    data_array_wen  = 1'b1;
                    data_array_wben = w_word_wben;
                    dirty_d[w_idx]  = 1'b1;
                    state_d         = S_WAIT;
                end
                S_EP: begin
                    tag_array_ren     = 1'b1;
                    data_array_ren    = 1'b1;
                    evict_addr_reg_en = 1'b1;
                    read_data_reg_en  = 1'b1;
                    state_d           = S_ER;
                end
                S_ER: begin
                    memreq_val  = 1'b1;
                    memreq_type = 3'd1;
                    if (memreq_rdy) state_d = S_EW;
                end
                S_EW: begin
                    memresp_rdy = 1'b1;
                    if (memresp_val) state_d = S_RR;
                end
                S_RR: begin
                    memreq_val          = 1'b1;
                    memreq_addr_mux_sel = 1'b1;
                    if (memreq_rdy) state_d = S_RW;
                end
                S_RW: begin
                    memresp_rdy = 1'b1;
                    memresp_en  = 1'b1;
                    if (memresp_val) state_d = S_RU;
                end
                S_RU: begin
                    tag_array_wen      = 1'b1;
                    data_array_wen     = 1'b1;
                    data_array_wben    = 16'hFFFF;
                    write_data_mux_sel = 1'b1;
                    valid_d[w_idx]     = 1'b1;
                    dirty_d[w_idx]     = 1'b0;
                    state_d            = w_is_wr ? S_WD : S_RD;
                end
                S_WAIT: begin
                    cacheresp_val     = 1'b1;
                    read_word_mux_sel = w_is_rd ? {1'b0, w_off} : 3'd4;
                    if (cacheresp_rdy) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
